// File: rtl/jtag_dbg_pkg.sv
// Shared constants and entry layout for the JTAG debug command bridge.
package jtag_dbg_pkg;

  localparam int DEF_IR_W        = 2;
  localparam int DEF_DR_W        = 38;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ACT_BIT     = 37;

  localparam int DEF_ENTRY_W = DEF_IR_W + DEF_DR_W;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int entry_w(input int ir_w, input int dr_w);
    return ir_w + dr_w;
  endfunction

  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_DR_W-1:0] dr;
  } entry_t;

endpackage

// File: rtl/jtag_dbg_strobe_sync.sv
// Brings an asynchronous TCK-domain update level into clk and emits a
// single-cycle pulse on its rising edge.
module jtag_dbg_strobe_sync
  import jtag_dbg_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  (* ASYNC_REG = "TRUE" *) logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the JTAG debug path: synchronises IR/DR update strobes,
// queues completed scans in a FWFT FIFO and issues per-instruction strobes on pop.
module jtag_debug_cmd_bridge
  import jtag_dbg_pkg::*;
#(
  parameter  int IR_W        = DEF_IR_W,
  parameter  int DR_W        = DEF_DR_W,
  parameter  int DEPTH       = DEF_DEPTH,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int ACT_BIT     = DEF_ACT_BIT,
  localparam int N_INST      = 2**IR_W,
  localparam int LVL_W       = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DR_W-1:0]   sr,
  input  logic              vs_uir,
  input  logic              vs_udr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [DR_W-1:0]   cmd_dr,
  output logic [DR_W-1:0]   jdo,
  output logic [N_INST-1:0] take_action,
  output logic [N_INST-1:0] take_no_action,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(IR_W, DR_W);

  function automatic logic [N_INST-1:0] inst_onehot(input logic [IR_W-1:0] ir);
    return N_INST'(1) << ir;
  endfunction

  logic               uir_p;
  logic               udr_p;
  logic [IR_W-1:0]    ir_q;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  jtag_dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_uir),
    .pulse    (uir_p)
  );

  jtag_dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_udr),
    .pulse    (udr_p)
  );

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_valid = !empty;
  assign pop       = cmd_valid & cmd_ready;
  // A full FIFO still accepts a scan when the head leaves on the same edge.
  assign push_ok   = udr_p & (!full | pop);
  assign drop      = udr_p & full & !pop;
  assign level     = LVL_W'(wr_ptr - rd_ptr);

  // Storage is never reset; gating by cmd_valid keeps the head outputs at 0 when empty.
  assign head   = cmd_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign cmd_ir = head[ENTRY_W-1 -: IR_W];
  assign cmd_dr = head[DR_W-1:0];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {ir_q, sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (uir_p) begin
        ir_q <= ir_in;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Pop stage: strobes are single-cycle, jdo holds the last consumed scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo <= cmd_dr;
        if (cmd_dr[ACT_BIT]) begin
          take_action <= inst_onehot(cmd_ir);
        end else begin
          take_no_action <= inst_onehot(cmd_ir);
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
// Scoreboard bench for jtag_debug_cmd_bridge: stimulus queues expected commands,
// a negedge monitor checks each pop and the strobes that follow it.
module tb_jtag_debug_cmd_bridge;

  localparam int IR_W   = 2;
  localparam int DR_W   = 38;
  localparam int DEPTH  = 4;
  localparam int N_INST = 4;
  localparam int LVL_W  = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [IR_W-1:0]   ir_in;
  logic [DR_W-1:0]   sr;
  logic              vs_uir;
  logic              vs_udr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DR_W-1:0]   cmd_dr;
  logic [DR_W-1:0]   jdo;
  logic [N_INST-1:0] take_action;
  logic [N_INST-1:0] take_no_action;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              clr_overflow;

  jtag_debug_cmd_bridge #(
    .IR_W(IR_W), .DR_W(DR_W), .DEPTH(DEPTH), .SYNC_STAGES(2), .ACT_BIT(37)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_dr         (cmd_dr),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .level          (level),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DR_W-1:0]   dr;
    logic [N_INST-1:0] ta;
    logic [N_INST-1:0] tna;
  } exp_t;

  exp_t            exp_q[$];
  int              total = 0;
  int              bad   = 0;
  logic [IR_W-1:0] cur_ir = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Monitor: compare head on every pop, then the strobes/jdo one cycle later.
  exp_t mon_e;
  logic mon_pend = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        chk("pop_take_action", 64'(take_action), 64'(mon_e.ta));
        chk("pop_take_no_action", 64'(take_no_action), 64'(mon_e.tna));
        chk("pop_jdo", 64'(jdo), 64'(mon_e.dr));
      end else begin
        chk("idle_take_action", 64'(take_action), 64'(0));
        chk("idle_take_no_action", 64'(take_no_action), 64'(0));
      end
      mon_pend = 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(cmd_dr), 64'(0) - 64'(1));
        end else begin
          mon_e = exp_q.pop_front();
          chk("head_ir", 64'(cmd_ir), 64'(mon_e.ir));
          chk("head_dr", 64'(cmd_dr), 64'(mon_e.dr));
          mon_pend = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                          input logic [N_INST-1:0] ta, input logic [N_INST-1:0] tna);
    exp_t e;
    e.ir  = ir;
    e.dr  = dr;
    e.ta  = ta;
    e.tna = tna;
    exp_q.push_back(e);
  endtask

  task automatic set_ir(input logic [IR_W-1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    tick(2);
    vs_uir = 1'b0;
    tick(2);
    cur_ir = ir;
  endtask

  task automatic scan(input logic [DR_W-1:0] dr, input logic [N_INST-1:0] ta,
                      input logic [N_INST-1:0] tna, input bit accept);
    sr = dr;
    if (accept) push_exp(cur_ir, dr, ta, tna);
    vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    int n = 0;
    cmd_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    tick(2);
    cmd_ready = 1'b0;
    chk("drain_left", 64'(exp_q.size()), 64'(0));
    chk("drain_valid", 64'(cmd_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;
    tick(3);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_jdo", 64'(jdo), 64'(0));
    chk("rst_take_action", 64'(take_action), 64'(0));
    chk("rst_take_no_action", 64'(take_no_action), 64'(0));
    chk("rst_cmd_ir", 64'(cmd_ir), 64'(0));
    chk("rst_cmd_dr", 64'(cmd_dr), 64'(0));
    reset_n = 1'b1;
    tick(2);

    // Action scan on instruction 2, with latency checked edge by edge.
    set_ir(2'd2);
    sr = 38'h20_0000_1234;
    push_exp(2'd2, 38'h20_0000_1234, 4'b0100, 4'b0000);
    vs_udr = 1'b1;
    tick(1);
    chk("lat_edge0_valid", 64'(cmd_valid), 64'(0));
    tick(1);
    chk("lat_edge1_valid", 64'(cmd_valid), 64'(0));
    tick(1);
    chk("lat_edge2_valid", 64'(cmd_valid), 64'(1));
    chk("lat_cmd_ir", 64'(cmd_ir), 64'(2));
    chk("lat_cmd_dr", 64'(cmd_dr), 64'h20_0000_1234);
    chk("lat_level", 64'(level), 64'(1));
    vs_udr = 1'b0;
    tick(1);
    drain();
    chk("jdo_held", 64'(jdo), 64'h20_0000_1234);

    // No-action scan on the same instruction.
    scan(38'h00_0000_1234, 4'b0000, 4'b0100, 1'b1);
    drain();

    // Five scans into a 4-deep FIFO with no consumer: fifth is dropped.
    set_ir(2'd1);
    scan(38'h20_0000_0001, 4'b0010, 4'b0000, 1'b1);
    scan(38'h00_0000_0002, 4'b0000, 4'b0010, 1'b1);
    scan(38'h20_0000_0003, 4'b0010, 4'b0000, 1'b1);
    scan(38'h00_0000_0004, 4'b0000, 4'b0010, 1'b1);
    scan(38'h20_0000_0005, 4'b0000, 4'b0000, 1'b0);
    chk("full_level", 64'(level), 64'(4));
    chk("full_overflow", 64'(overflow), 64'(1));
    drain();
    chk("drained_level", 64'(level), 64'(0));
    chk("overflow_sticky", 64'(overflow), 64'(1));
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("overflow_cleared", 64'(overflow), 64'(0));

    // Full FIFO with push and pop on the same edge.
    scan(38'h20_0000_0011, 4'b0010, 4'b0000, 1'b1);
    scan(38'h00_0000_0012, 4'b0000, 4'b0010, 1'b1);
    scan(38'h20_0000_0013, 4'b0010, 4'b0000, 1'b1);
    scan(38'h00_0000_0014, 4'b0000, 4'b0010, 1'b1);
    chk("refill_level", 64'(level), 64'(4));
    set_ir(2'd3);
    sr = 38'h20_0000_00AA;
    push_exp(2'd3, 38'h20_0000_00AA, 4'b1000, 4'b0000);
    vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("coinc_level", 64'(level), 64'(4));
    chk("coinc_overflow", 64'(overflow), 64'(0));
    vs_udr = 1'b0;
    tick(2);
    drain();

    // Clear request colliding with a dropped push: set wins.
    scan(38'h00_0000_0021, 4'b0000, 4'b1000, 1'b1);
    scan(38'h20_0000_0022, 4'b1000, 4'b0000, 1'b1);
    scan(38'h00_0000_0023, 4'b0000, 4'b1000, 1'b1);
    scan(38'h20_0000_0024, 4'b1000, 4'b0000, 1'b1);
    sr = 38'h20_0000_00EE;
    vs_udr = 1'b1;
    tick(2);
    clr_overflow = 1'b1;
    tick(1);
    chk("ovf_set_wins", 64'(overflow), 64'(1));
    tick(1);
    chk("ovf_clear_next", 64'(overflow), 64'(0));
    clr_overflow = 1'b0;
    vs_udr = 1'b0;
    tick(2);
    chk("drop_level", 64'(level), 64'(4));
    drain();

    // Reset mid-operation with entries queued and a scan inside the synchroniser.
    scan(38'h20_0000_0031, 4'b1000, 4'b0000, 1'b1);
    scan(38'h20_0000_0032, 4'b1000, 4'b0000, 1'b1);
    scan(38'h20_0000_0033, 4'b1000, 4'b0000, 1'b1);
    chk("pre_rst_level", 64'(level), 64'(3));
    sr = 38'h20_0000_0034;
    vs_udr = 1'b1;
    tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(cmd_valid), 64'(0));
    chk("midrst_level", 64'(level), 64'(0));
    exp_q.delete();
    vs_udr = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(6);
    chk("no_phantom_valid", 64'(cmd_valid), 64'(0));
    chk("no_phantom_level", 64'(level), 64'(0));

    // IR register was cleared by reset: next scan lands on instruction 0.
    cur_ir = 2'd0;
    scan(38'h3F_FFFF_FFFF, 4'b0001, 4'b0000, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
